// File: rtl/ddr_global_pkg.sv
// Shared DDR common types: CSR sequencer opcodes, error codes and FSM states.
package ddr_global_pkg;

  typedef enum logic [1:0] {
    OpWrite = 2'd0,
    OpPoll  = 2'd1,
    OpRmw   = 2'd2,
    OpWait  = 2'd3
  } CSR_SEQ_OP_T;

  typedef enum logic [1:0] {
    ErrNone    = 2'd0,
    ErrBusErr  = 2'd1,
    ErrTimeout = 2'd2
  } CSR_SEQ_ERR_T;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWr,
    StRd,
    StRmwWr,
    StGap,
    StWait,
    StAbort
  } csr_seq_state_t;

endpackage

// File: rtl/ddr_cmn_csr_seq_fifo.sv
// Command FIFO for the CSR sequencer: show-ahead read, synchronous flush,
// simultaneous push/pop accepted when full.
module ddr_cmn_csr_seq_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  // A pop frees the slot the push lands in, so full does not block it.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_rdata   = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst_n && !i_flush && w_do_push) begin
      r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end
  end

endmodule

// File: rtl/ddr_cmn_csr_seq.sv
// CSR command sequencer: queues WRITE/POLL/RMW/WAIT commands and replays them
// on a ready-handshaked CSR bus, aborting on bus error or poll timeout.
module ddr_cmn_csr_seq
  import ddr_global_pkg::*;
#(
  parameter int unsigned AWIDTH   = 32,
  parameter int unsigned DWIDTH   = 32,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned POLL_GAP = 4,
  parameter int unsigned TMO_W    = 10
) (
  input  logic              i_hclk,
  input  logic              i_hreset_n,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [1:0]        i_cmd_op,
  input  logic [AWIDTH-1:0] i_cmd_addr,
  input  logic [DWIDTH-1:0] i_cmd_data,
  input  logic [DWIDTH-1:0] i_cmd_mask,
  output logic              o_write,
  output logic              o_read,
  output logic [AWIDTH-1:0] o_addr,
  output logic [DWIDTH-1:0] o_wdata,
  input  logic [DWIDTH-1:0] i_rdata,
  input  logic              i_error,
  input  logic              i_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [1:0]        o_err_code,
  input  logic              i_clr_err
);
  localparam int unsigned   FW       = 2 + AWIDTH + 2 * DWIDTH;
  localparam int unsigned   GW       = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GW-1:0] GapLast  = (POLL_GAP > 1) ? GW'(POLL_GAP - 1) : '0;
  localparam logic [TMO_W-1:0] RetryMax = '1;

  csr_seq_state_t    r_state,      w_state_nxt;
  logic              r_write,      w_write_nxt;
  logic              r_read,       w_read_nxt;
  logic [AWIDTH-1:0] r_addr,       w_addr_nxt;
  logic [DWIDTH-1:0] r_wdata,      w_wdata_nxt;
  logic              r_done,       w_done_nxt;
  logic              r_err,        w_err_nxt;
  CSR_SEQ_ERR_T      r_err_code,   w_err_code_nxt;
  CSR_SEQ_ERR_T      r_abort_code, w_abort_code_nxt;
  CSR_SEQ_OP_T       r_op,         w_op_nxt;
  logic [DWIDTH-1:0] r_data,       w_data_nxt;
  logic [DWIDTH-1:0] r_mask,       w_mask_nxt;
  logic [TMO_W-1:0]  r_retry,      w_retry_nxt;
  logic [GW-1:0]     r_gap,        w_gap_nxt;
  logic [15:0]       r_wait,       w_wait_nxt;

  logic              w_push, w_pop, w_flush, w_full, w_empty;
  logic [FW-1:0]     w_fifo_wdata, w_fifo_rdata;
  CSR_SEQ_OP_T       w_f_op;
  logic [AWIDTH-1:0] w_f_addr;
  logic [DWIDTH-1:0] w_f_data, w_f_mask;

  assign w_fifo_wdata = {i_cmd_op, i_cmd_addr, i_cmd_data, i_cmd_mask};
  assign w_f_op       = CSR_SEQ_OP_T'(w_fifo_rdata[FW-1 -: 2]);
  assign w_f_addr     = w_fifo_rdata[2*DWIDTH +: AWIDTH];
  assign w_f_data     = w_fifo_rdata[DWIDTH +: DWIDTH];
  assign w_f_mask     = w_fifo_rdata[0 +: DWIDTH];

  // Pushes are refused while an error is pending and in the flushing cycle.
  assign o_cmd_ready  = (!w_full || w_pop) && !r_err && (r_state != StAbort);
  assign w_push       = i_cmd_valid && o_cmd_ready;

  ddr_cmn_csr_seq_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_hclk),
    .i_rst_n (i_hreset_n),
    .i_flush (w_flush),
    .i_push  (w_push),
    .i_wdata (w_fifo_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_state_nxt      = r_state;
    w_write_nxt      = r_write;
    w_read_nxt       = r_read;
    w_addr_nxt       = r_addr;
    w_wdata_nxt      = r_wdata;
    w_done_nxt       = 1'b0;
    w_err_nxt        = r_err;
    w_err_code_nxt   = r_err_code;
    w_abort_code_nxt = r_abort_code;
    w_op_nxt         = r_op;
    w_data_nxt       = r_data;
    w_mask_nxt       = r_mask;
    w_retry_nxt      = r_retry;
    w_gap_nxt        = r_gap;
    w_wait_nxt       = r_wait;
    w_pop            = 1'b0;
    w_flush          = 1'b0;

    if (i_clr_err) begin
      w_err_nxt      = 1'b0;
      w_err_code_nxt = ErrNone;
    end

    unique case (r_state)
      StIdle: if (!w_empty) w_state_nxt = StFetch;
      StFetch: begin
        if (w_empty) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = StIdle;
        end else begin
          w_pop       = 1'b1;
          w_op_nxt    = w_f_op;
          w_data_nxt  = w_f_data;
          w_mask_nxt  = w_f_mask;
          w_addr_nxt  = w_f_addr;
          w_retry_nxt = '0;
          unique case (w_f_op)
            OpWrite: begin
              w_wdata_nxt = w_f_data;
              w_write_nxt = 1'b1;
              w_state_nxt = StWr;
            end
            OpPoll, OpRmw: begin
              w_read_nxt  = 1'b1;
              w_state_nxt = StRd;
            end
            OpWait: begin
              w_wait_nxt  = 16'(w_f_data);
              w_state_nxt = StWait;
            end
          endcase
        end
      end
      StWr, StRmwWr: begin
        if (i_ready) begin
          w_write_nxt = 1'b0;
          if (i_error) begin
            w_abort_code_nxt = ErrBusErr;
            w_state_nxt      = StAbort;
          end else begin
            w_state_nxt = StFetch;
          end
        end
      end
      StRd: begin
        if (i_ready) begin
          w_read_nxt = 1'b0;
          if (i_error) begin
            w_abort_code_nxt = ErrBusErr;
            w_state_nxt      = StAbort;
          end else if (r_op == OpRmw) begin
            w_wdata_nxt = (i_rdata & ~r_mask) | (r_data & r_mask);
            w_write_nxt = 1'b1;
            w_state_nxt = StRmwWr;
          end else if (((i_rdata ^ r_data) & r_mask) == '0) begin
            w_state_nxt = StFetch;
          end else if (r_retry == RetryMax) begin
            w_abort_code_nxt = ErrTimeout;
            w_state_nxt      = StAbort;
          end else begin
            w_gap_nxt   = '0;
            w_state_nxt = StGap;
          end
        end
      end
      StGap: begin
        if (r_gap == GapLast) begin
          w_retry_nxt = r_retry + 1'b1;
          w_read_nxt  = 1'b1;
          w_state_nxt = StRd;
        end else begin
          w_gap_nxt = r_gap + 1'b1;
        end
      end
      // A zero count still occupies one cycle.
      StWait: begin
        if (r_wait <= 16'd1) w_state_nxt = StFetch;
        else                 w_wait_nxt  = r_wait - 16'd1;
      end
      StAbort: begin
        w_flush        = 1'b1;
        w_err_nxt      = 1'b1;
        w_err_code_nxt = r_abort_code;
        w_state_nxt    = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_hclk) begin
    if (!i_hreset_n) begin
      r_state      <= StIdle;
      r_write      <= 1'b0;
      r_read       <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_err_code   <= ErrNone;
      r_abort_code <= ErrNone;
      r_op         <= OpWrite;
      r_data       <= '0;
      r_mask       <= '0;
      r_retry      <= '0;
      r_gap        <= '0;
      r_wait       <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_write      <= w_write_nxt;
      r_read       <= w_read_nxt;
      r_addr       <= w_addr_nxt;
      r_wdata      <= w_wdata_nxt;
      r_done       <= w_done_nxt;
      r_err        <= w_err_nxt;
      r_err_code   <= w_err_code_nxt;
      r_abort_code <= w_abort_code_nxt;
      r_op         <= w_op_nxt;
      r_data       <= w_data_nxt;
      r_mask       <= w_mask_nxt;
      r_retry      <= w_retry_nxt;
      r_gap        <= w_gap_nxt;
      r_wait       <= w_wait_nxt;
    end
  end

  assign o_write    = r_write;
  assign o_read     = r_read;
  assign o_addr     = r_addr;
  assign o_wdata    = r_wdata;
  assign o_busy     = (r_state != StIdle);
  assign o_done     = r_done;
  assign o_err      = r_err;
  assign o_err_code = r_err_code;

endmodule

// File: tb/tb_ddr_cmn_csr_seq.sv
// Self-checking bench for ddr_cmn_csr_seq: vector table, directed corner cases
// and random command batches against a memory-backed CSR slave model.
module tb_ddr_cmn_csr_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_addr, cmd_data, cmd_mask;
  logic        wr, rd;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        error, ready;
  logic        busy, done, err;
  logic [1:0]  err_code;
  logic        clr_err;

  always #5 clk = ~clk;

  ddr_cmn_csr_seq #(
    .AWIDTH   (32),
    .DWIDTH   (32),
    .DEPTH    (4),
    .POLL_GAP (4),
    .TMO_W    (2)
  ) dut (
    .i_hclk      (clk),
    .i_hreset_n  (rst_n),
    .i_cmd_valid (cmd_valid),
    .o_cmd_ready (cmd_ready),
    .i_cmd_op    (cmd_op),
    .i_cmd_addr  (cmd_addr),
    .i_cmd_data  (cmd_data),
    .i_cmd_mask  (cmd_mask),
    .o_write     (wr),
    .o_read      (rd),
    .o_addr      (addr),
    .o_wdata     (wdata),
    .i_rdata     (rdata),
    .i_error     (error),
    .i_ready     (ready),
    .o_busy      (busy),
    .o_done      (done),
    .o_err       (err),
    .o_err_code  (err_code),
    .i_clr_err   (clr_err)
  );

  typedef struct {
    bit          wr;
    logic [31:0] a;
    logic [31:0] d;
  } acc_t;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] m;
    logic [31:0] init;
    int          nacc;
    int          nwr;
    logic [31:0] fin;
    int          busyc;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  // CSR slave model and monitors
  logic [31:0] tb_mem [16];
  logic [31:0] rd_script [$];
  acc_t        log_q [$];
  int stall_n = 0;
  bit stall_rand = 0;
  int err_at = 0;
  int n_acc, busy_cnt, done_cnt, wr_cyc, rd_cyc, idle_busy;
  int hold_tot = 0;
  int both_tot = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_stats();
    n_acc = 0; busy_cnt = 0; done_cnt = 0; wr_cyc = 0; rd_cyc = 0; idle_busy = 0;
    log_q.delete();
  endtask

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] m, input int tries, output bit acc);
    acc = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d; cmd_mask = m;
    for (int i = 0; i < tries && !acc; i++) begin
      acc = cmd_ready;
      cycle();
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    bit got = 0;
    for (int i = 0; i < budget && !got; i++) begin
      cycle();
      if (done || err) got = 1;
    end
    if (!got) check({name, "_timeout"}, 32'(got), 32'd1);
    cycle();
  endtask

  initial begin : responder
    bit          have_snap = 0;
    int          pend_wait = 0;
    int          pend_need = 0;
    logic [65:0] snap = '0;
    ready = 1'b0; error = 1'b0; rdata = '0;
    forever begin
      @(negedge clk);
      ready = 1'b0; error = 1'b0;
      if (rst_n === 1'b1) begin
        if (busy) busy_cnt++;
        if (done) done_cnt++;
        if (wr) wr_cyc++;
        if (rd) rd_cyc++;
        if (wr && rd) both_tot++;
        if (busy && !wr && !rd) idle_busy++;
        if (wr || rd) begin
          if (!have_snap) begin
            have_snap = 1;
            snap = {wr, rd, addr, wdata};
            pend_wait = 0;
            pend_need = stall_rand ? int'($urandom_range(0, 2)) : stall_n;
          end else if (snap !== {wr, rd, addr, wdata}) begin
            hold_tot++;
          end
          if (pend_wait < pend_need) begin
            pend_wait++;
          end else begin
            ready = 1'b1;
            n_acc++;
            have_snap = 0;
            log_q.push_back('{wr, addr, wdata});
            if (rd) begin
              if (rd_script.size() > 0) rdata = rd_script.pop_front();
              else                      rdata = tb_mem[addr[5:2]];
            end else begin
              tb_mem[addr[5:2]] = wdata;
            end
            if (n_acc == err_at) error = 1'b1;
          end
        end else begin
          have_snap = 0;
        end
      end else begin
        have_snap = 0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
    $fatal(1);
  end

  initial begin : main
    vec_t        vt [11];
    bit          acc;
    logic [1:0]  op;
    logic [31:0] a, d, m, nv;
    logic [31:0] mm [16];
    acc_t        exp_q [$];
    int          nc, mism;

    vt[0]  = '{2'd0, 32'h00, 32'h000000A5, 32'h0,        32'h0,        1, 1, 32'h000000A5, 3};
    vt[1]  = '{2'd0, 32'h04, 32'hDEADBEEF, 32'h0,        32'h1,        1, 1, 32'hDEADBEEF, 3};
    vt[2]  = '{2'd2, 32'h10, 32'h000000F0, 32'h000000F0, 32'h00001234, 2, 1, 32'h000012F4, 4};
    vt[3]  = '{2'd2, 32'h14, 32'hFFFF0000, 32'h0000FFFF, 32'h12345678, 2, 1, 32'h12340000, 4};
    vt[4]  = '{2'd2, 32'h18, 32'hAAAAAAAA, 32'hFFFFFFFF, 32'h55555555, 2, 1, 32'hAAAAAAAA, 4};
    vt[5]  = '{2'd2, 32'h1C, 32'h12345678, 32'h0,        32'hCAFEF00D, 2, 1, 32'hCAFEF00D, 4};
    vt[6]  = '{2'd1, 32'h20, 32'h00000080, 32'h00000080, 32'h000000FF, 1, 0, 32'h000000FF, 3};
    vt[7]  = '{2'd1, 32'h24, 32'hFFFFFFFF, 32'h0,        32'h0,        1, 0, 32'h0,        3};
    vt[8]  = '{2'd3, 32'h28, 32'h0,        32'h0,        32'h7,        0, 0, 32'h7,        3};
    vt[9]  = '{2'd3, 32'h28, 32'h5,        32'h0,        32'h7,        0, 0, 32'h7,        7};
    vt[10] = '{2'd3, 32'h28, 32'h00010002, 32'h0,        32'h7,        0, 0, 32'h7,        4};

    for (int i = 0; i < 16; i++) tb_mem[i] = '0;
    cmd_valid = 0; cmd_op = 0; cmd_addr = 0; cmd_data = 0; cmd_mask = 0; clr_err = 0;
    rst_n = 1'b0;
    clear_stats();
    repeat (3) cycle();
    check("rst_ready", 32'(cmd_ready), 1);
    check("rst_wr_rd", {30'd0, wr, rd}, 0);
    check("rst_addr", addr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_flags", {28'd0, busy, done, err, 1'b0}, 0);
    check("rst_code", 32'(err_code), 0);
    rst_n = 1'b1;
    cycle();

    // Single-command vector table, bus always ready
    foreach (vt[k]) begin
      tb_mem[vt[k].a[5:2]] = vt[k].init;
      clear_stats();
      push(vt[k].op, vt[k].a, vt[k].d, vt[k].m, 4, acc);
      check($sformatf("vec%0d_push", k), 32'(acc), 1);
      wait_done(100, $sformatf("vec%0d", k));
      check($sformatf("vec%0d_nacc", k), n_acc, vt[k].nacc);
      check($sformatf("vec%0d_wrcyc", k), wr_cyc, vt[k].nwr);
      check($sformatf("vec%0d_mem", k), tb_mem[vt[k].a[5:2]], vt[k].fin);
      check($sformatf("vec%0d_busy", k), busy_cnt, vt[k].busyc);
      check($sformatf("vec%0d_done", k), done_cnt, 1);
      check($sformatf("vec%0d_err", k), 32'(err), 0);
    end

    // POLL matching on third read
    clear_stats();
    rd_script.push_back(32'h0); rd_script.push_back(32'h0); rd_script.push_back(32'h1);
    push(2'd1, 32'h0C, 32'h1, 32'h1, 4, acc);
    wait_done(200, "poll3");
    check("poll3_reads", rd_cyc, 3);
    check("poll3_nacc", n_acc, 3);
    check("poll3_gapidle", idle_busy, 10);
    check("poll3_busy", busy_cnt, 13);
    check("poll3_done", done_cnt, 1);

    // Five-cycle stall on a write
    clear_stats();
    stall_n = 5;
    push(2'd0, 32'h3C, 32'h5A5A, 32'h0, 4, acc);
    wait_done(100, "stall");
    stall_n = 0;
    check("stall_wrcyc", wr_cyc, 6);
    check("stall_nacc", n_acc, 1);
    check("stall_busy", busy_cnt, 8);
    check("stall_mem", tb_mem[15], 32'h5A5A);
    check("stall_hold", hold_tot, 0);

    // Bus error on the second of four queued writes
    clear_stats();
    err_at = 2;
    for (int i = 0; i < 4; i++) begin
      push(2'd0, 32'h20 + 32'(4 * i), 32'h100 + 32'(i), 32'h0, 4, acc);
      check($sformatf("err_push%0d", i), 32'(acc), 1);
    end
    wait_done(200, "err");
    check("err_nacc", n_acc, 2);
    check("err_flag", 32'(err), 1);
    check("err_code", 32'(err_code), 1);
    repeat (10) cycle();
    check("err_noacc", n_acc, 2);
    check("err_done", done_cnt, 0);
    check("err_idle", 32'(busy), 0);
    check("err_ready", 32'(cmd_ready), 0);
    push(2'd0, 32'h30, 32'h77, 32'h0, 1, acc);
    check("err_drop", 32'(acc), 0);
    err_at = 0;
    clr_err = 1'b1;
    cycle();
    clr_err = 1'b0;
    check("clr_flag", 32'(err), 0);
    check("clr_code", 32'(err_code), 0);
    check("clr_ready", 32'(cmd_ready), 1);
    repeat (5) cycle();
    check("clr_nacc", n_acc, 2);
    clear_stats();
    push(2'd0, 32'h30, 32'h77, 32'h0, 4, acc);
    wait_done(100, "post_err");
    check("post_err_nacc", n_acc, 1);
    check("post_err_busy", busy_cnt, 3);
    check("post_err_done", done_cnt, 1);

    // POLL that never matches: 3 retries then timeout
    clear_stats();
    tb_mem[8] = 32'h0;
    push(2'd1, 32'h20, 32'h1, 32'h1, 4, acc);
    wait_done(300, "tmo");
    check("tmo_reads", rd_cyc, 4);
    check("tmo_flag", 32'(err), 1);
    check("tmo_code", 32'(err_code), 2);
    check("tmo_done", done_cnt, 0);
    clr_err = 1'b1;
    cycle();
    clr_err = 1'b0;

    // Reset in the middle of a long WAIT
    push(2'd3, 32'h0, 32'd200, 32'h0, 4, acc);
    repeat (10) cycle();
    check("wait_busy", 32'(busy), 1);
    rst_n = 1'b0;
    cycle();
    check("wrst_ready", 32'(cmd_ready), 1);
    check("wrst_wr_rd", {30'd0, wr, rd}, 0);
    check("wrst_addr", addr, 0);
    check("wrst_wdata", wdata, 0);
    check("wrst_flags", {29'd0, busy, done, err}, 0);
    check("wrst_code", 32'(err_code), 0);
    rst_n = 1'b1;
    cycle();
    clear_stats();
    push(2'd0, 32'h08, 32'h99, 32'h0, 4, acc);
    wait_done(100, "post_rst");
    check("post_rst_busy", busy_cnt, 3);
    check("post_rst_nacc", n_acc, 1);

    // Reset in the middle of a stalled write
    clear_stats();
    stall_n = 10;
    push(2'd0, 32'h34, 32'h1111, 32'h0, 4, acc);
    repeat (4) cycle();
    check("mid_wr_active", 32'(wr), 1);
    rst_n = 1'b0;
    cycle();
    check("mid_wr_dropped", 32'(wr), 0);
    rst_n = 1'b1;
    stall_n = 0;
    repeat (20) cycle();
    check("mid_no_resume", n_acc, 0);
    check("mid_idle", 32'(busy), 0);

    // Random command batches with random bus stalls
    stall_rand = 1;
    for (int b = 0; b < 30; b++) begin
      mm = tb_mem;
      exp_q.delete();
      clear_stats();
      nc = $urandom_range(1, 4);
      for (int c = 0; c < nc; c++) begin
        op = 2'($urandom_range(0, 3));
        a  = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        d  = $urandom;
        m  = $urandom;
        case (op)
          2'd0: begin
            mm[a[5:2]] = d;
            exp_q.push_back('{1'b1, a, d});
          end
          2'd1: begin
            d = (mm[a[5:2]] & m) | (d & ~m);
            exp_q.push_back('{1'b0, a, 32'h0});
          end
          2'd2: begin
            nv = (mm[a[5:2]] & ~m) | (d & m);
            mm[a[5:2]] = nv;
            exp_q.push_back('{1'b0, a, 32'h0});
            exp_q.push_back('{1'b1, a, nv});
          end
          default: d = {16'($urandom), 16'($urandom_range(0, 3))};
        endcase
        push(op, a, d, m, 20, acc);
        check($sformatf("rnd%0d_push%0d", b, c), 32'(acc), 1);
      end
      wait_done(400, $sformatf("rnd%0d", b));
      check($sformatf("rnd%0d_done", b), done_cnt, 1);
      check($sformatf("rnd%0d_err", b), 32'(err), 0);
      check($sformatf("rnd%0d_len", b), log_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
        check($sformatf("rnd%0d_kind%0d", b, i), 32'(log_q[i].wr), 32'(exp_q[i].wr));
        check($sformatf("rnd%0d_addr%0d", b, i), log_q[i].a, exp_q[i].a);
        if (exp_q[i].wr) check($sformatf("rnd%0d_wdata%0d", b, i), log_q[i].d, exp_q[i].d);
      end
      mism = 0;
      for (int i = 0; i < 16; i++) if (tb_mem[i] !== mm[i]) mism++;
      check($sformatf("rnd%0d_memimg", b), mism, 0);
    end
    stall_rand = 0;

    check("hold_stable", hold_tot, 0);
    check("wr_rd_exclusive", both_tot, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ddr_cmn_csr_seq.md
DDR_CMN_CSR_SEQ -- requirements
Module: ddr_cmn_csr_seq

Interface
REQ-001 SHALL have parameter AWIDTH, default 32, meaning CSR address width.
REQ-002 SHALL have parameter DWIDTH, default 32, meaning CSR data width.
REQ-003 SHALL have parameter DEPTH, default 4, meaning command FIFO entries (power of 2).
REQ-004 SHALL have parameter POLL_GAP, default 4, meaning idle cycles between poll reads.
REQ-005 SHALL have parameter TMO_W, default 10, meaning poll-retry counter width.
REQ-006 SHALL use one clock; reset is synchronous and active-low.
REQ-007 SHALL have port i_hclk  input  1  clock.
REQ-008 SHALL have port i_hreset_n  input  1  synchronous active-low reset.
REQ-009 SHALL have port i_cmd_valid  input  1  command push request.
REQ-010 SHALL have port o_cmd_ready  output  1  FIFO not full.
REQ-011 SHALL have port i_cmd_op  input  2  opcode: WRITE=0, POLL=1, RMW=2, WAIT=3.
REQ-012 SHALL have ports i_cmd_addr  input  AWIDTH; i_cmd_data  input  DWIDTH; i_cmd_mask  input  DWIDTH  command operands.
REQ-013 SHALL have ports o_write, o_read  output  1; o_addr  output  AWIDTH; o_wdata  output  DWIDTH  CSR bus request.
REQ-014 SHALL have ports i_rdata  input  DWIDTH; i_error, i_ready  input  1  CSR bus response.
REQ-015 SHALL have ports o_busy  output  1; o_done  output  1 (pulse); o_err  output  1 (sticky); o_err_code  output  2; i_clr_err  input  1.

Function
REQ-016 SHALL hold o_write/o_read, o_addr and o_wdata stable until the cycle i_ready=1; that cycle completes the access, and i_rdata/i_error are sampled in it.
REQ-017 SHALL never assert o_write and o_read in the same cycle.
REQ-018 SHALL use the FSM states IDLE, FETCH, WR, RD, RMW_WR, GAP, WAIT and ABORT.
REQ-019 SHALL pop one FIFO entry in FETCH and enter WR (WRITE), RD (POLL/RMW) or WAIT (WAIT). Issue SHALL start the cycle after the pop.
REQ-020 WRITE SHALL drive o_wdata=data to addr, then return to FETCH.
REQ-021 POLL SHALL read addr and retire when (rdata & mask)==(data & mask). Otherwise it SHALL spend POLL_GAP cycles in GAP, increment the retry count and re-read.
REQ-022 When the retry count reaches 2^TMO_W-1 without a match, POLL SHALL go to ABORT with code TIMEOUT=2.
REQ-023 RMW SHALL read addr, then write (rdata & ~mask) | (data & mask) in RMW_WR.
REQ-024 WAIT SHALL idle for data[15:0] cycles; a zero count SHALL take 1 cycle.
REQ-025 An i_error sampled on any completing access SHALL go to ABORT with code BUS_ERR=1.
REQ-026 ABORT SHALL flush the FIFO, set o_err, latch o_err_code and go to IDLE in 1 cycle; o_done SHALL NOT pulse.
REQ-027 o_done SHALL pulse 1 cycle when the FIFO drains with no error; o_busy=1 in every state except IDLE.
REQ-028 While o_err=1, pushes SHALL be dropped and o_cmd_ready=0 until i_clr_err; i_clr_err SHALL clear o_err and o_err_code to 0 in the next cycle.
REQ-029 A push and a pop in the same cycle on a full FIFO SHALL both be accepted, leaving occupancy unchanged.
REQ-030 A push in the same cycle as ABORT SHALL be discarded.
REQ-031 All data arithmetic SHALL be DWIDTH bitwise logic; there SHALL be no carries.

Reset
REQ-032 While i_hreset_n=0 at a clock edge, the block SHALL set: state IDLE; FIFO empty; o_cmd_ready=1; o_write=o_read=0; o_addr=o_wdata=0; o_busy=o_done=o_err=0; o_err_code=0; all counters 0.
REQ-033 A reset mid-access SHALL drop the request in the same edge; no partial command SHALL resume afterwards.

Structure
REQ-034 The opcode enum (CSR_SEQ_OP_T) and error-code enum (CSR_SEQ_ERR_T: NONE=0, BUS_ERR=1, TIMEOUT=2) SHALL live in ddr_global_pkg.
REQ-035 The command FIFO SHALL be the sub-module ddr_cmn_csr_seq_fifo (DEPTH entries; op, addr, data and mask stored as one word; synchronous flush input).

Verification
REQ-036 The bench SHALL push WRITE 0x0/0xA5 with i_ready=1: o_write high for 1 cycle, o_wdata=0xA5, then o_done pulses.
REQ-037 The bench SHALL push POLL 0x0C/data 0x1/mask 0x1 with rdata=0,0,1: exactly 3 reads, GAP of 4 cycles between reads, then o_done.
REQ-038 The bench SHALL push RMW 0x10/data 0xF0/mask 0xF0 with rdata 0x1234: write of 0x12F4.
REQ-039 The bench SHALL stall i_ready=0 for 5 cycles: o_addr/o_write hold steady and the write completes on the 6th cycle.
REQ-040 The bench SHALL drive i_error=1 on access 2 of 4 queued: o_err=1, o_err_code=1, no further accesses, FIFO empty, o_cmd_ready=0 until i_clr_err.
REQ-041 The bench SHALL push POLL that never matches with TMO_W=2: abort after 3 retries, o_err_code=2; then the bench SHALL assert reset mid-WAIT, and all outputs return to reset values.
